// File: rtl/mac_sim.sv
// mac_sim: stand-in Ethernet MAC transmit path.
// Frames arrive as 32-bit words, are buffered whole, and are replayed as a
// byte stream with an inter-frame gap once their eop word has been committed.
module mac_sim #(
  parameter int DEPTH      = 256,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        eop,
  input  logic        err,
  input  logic [1:0]  mod,
  output logic        rdy,
  input  logic        sop,
  input  logic        wren,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] last_len
);
  localparam int AW     = $clog2(DEPTH);
  localparam int IFG_M1 = IFG_CYCLES - 1;
  localparam logic [AW:0] FULL     = DEPTH[AW:0];
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0] IFG_LAST = IFG_M1[15:0];

  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} w_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_IFG} t_state_t;

  // Each entry is {eop, mod, data}
  logic [34:0] mem [DEPTH];

  logic [AW:0] wp, cp, rp;
  logic [AW:0] used, frame_used, waddr, words;
  logic        acc, oversize, pending;
  logic        store, commit, discard;
  logic [1:0]  werr_inc;
  logic [15:0] len_calc;
  w_state_t    w_state, w_next;

  t_state_t    t_state, t_next;
  logic [1:0]  bidx, last_idx;
  logic [34:0] cur;
  logic        byte_last;
  logic [7:0]  cur_byte;
  logic [15:0] ifg_cnt;

  assign used       = wp - rp;
  assign frame_used = wp - cp;
  assign rdy        = ~rst & (used < FULL);
  assign acc        = wren & rdy;
  assign pending    = (cp != rp);
  // A frame that has filled the whole buffer can never complete.
  assign oversize   = (w_state == W_FRAME) && (frame_used == FULL);

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write FSM next state
  always_comb begin
    w_next = w_state;
    if (oversize) begin
      w_next = W_DROP;
    end else if (acc) begin
      if (sop || w_state == W_FRAME) w_next = eop ? W_IDLE : W_FRAME;
      else                           w_next = W_DROP;
    end
  end

  // Write FSM outputs: store/commit/discard strobes and error increments.
  // A sop word always lands at cp, which also covers restarting an aborted frame.
  always_comb begin
    store    = 1'b0;
    commit   = 1'b0;
    discard  = 1'b0;
    werr_inc = 2'd0;
    waddr    = sop ? cp : wp;
    if (oversize) begin
      discard  = 1'b1;
      werr_inc = 2'd1;
    end else if (acc) begin
      if (sop && w_state == W_FRAME) werr_inc = 2'd1;
      if (sop || w_state == W_FRAME) begin
        store = 1'b1;
        if (eop && err) begin
          discard  = 1'b1;
          werr_inc = werr_inc + 2'd1;
        end else if (eop) begin
          commit = 1'b1;
        end
      end else if (w_state == W_IDLE) begin
        werr_inc = 2'd1;
      end
    end
  end

  assign words    = waddr + ONE - cp;
  assign len_calc = 16'({words, 2'b00}) - {14'd0, mod};

  // Frame buffer write port
  always_ff @(posedge clk) begin
    if (store) mem[waddr[AW-1:0]] <= {eop, mod, data};
  end

  // Write-side pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      cp       <= '0;
      err_cnt  <= '0;
      last_len <= '0;
    end else begin
      if (discard)    wp <= cp;
      else if (store) wp <= waddr + ONE;
      if (commit) begin
        cp       <= waddr + ONE;
        last_len <= len_calc;
      end
      err_cnt <= err_cnt + {14'd0, werr_inc};
    end
  end

  // Transmit FSM state register
  always_ff @(posedge clk) begin
    if (rst) t_state <= T_IDLE;
    else     t_state <= t_next;
  end

  // Transmit FSM next state; a frame already waiting at the end of the gap
  // starts directly so back-to-back frames are separated by exactly IFG_CYCLES
  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE:  if (pending) t_next = T_SEND;
      T_SEND:  if (byte_last && cur[34]) t_next = T_IFG;
      T_IFG:   if (ifg_cnt == IFG_LAST) t_next = pending ? T_SEND : T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  // Transmit FSM outputs: current word, byte select and end-of-word detect
  always_comb begin
    cur       = mem[rp[AW-1:0]];
    last_idx  = cur[34] ? (2'd3 - cur[33:32]) : 2'd3;
    byte_last = (bidx == last_idx);
    case (bidx)
      2'd0:    cur_byte = cur[31:24];
      2'd1:    cur_byte = cur[23:16];
      2'd2:    cur_byte = cur[15:8];
      default: cur_byte = cur[7:0];
    endcase
  end

  // Transmit datapath: registered byte stream, read pointer, gap timer
  always_ff @(posedge clk) begin
    if (rst) begin
      rp        <= '0;
      bidx      <= '0;
      ifg_cnt   <= '0;
      frame_cnt <= '0;
      tx_data   <= '0;
      tx_en     <= 1'b0;
    end else begin
      tx_en <= (t_state == T_SEND);
      if (t_state == T_SEND) begin
        tx_data <= cur_byte;
        if (byte_last) begin
          bidx <= '0;
          rp   <= rp + ONE;
          if (cur[34]) frame_cnt <= frame_cnt + 16'd1;
        end else begin
          bidx <= bidx + 2'd1;
        end
      end
      if (t_state == T_IFG) ifg_cnt <= (ifg_cnt == IFG_LAST) ? '0 : ifg_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_sim.sv
// tb_mac_sim: scoreboard bench for mac_sim; expected bytes are queued as
// frames are driven and popped as the DUT emits them.
module tb_mac_sim;
  localparam int DEPTH = 64;
  localparam int IFG   = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        sop = 1'b0, eop = 1'b0, err = 1'b0, wren = 1'b0;
  logic [1:0]  mod = '0;
  logic        rdy, tx_en;
  logic [7:0]  tx_data;
  logic [15:0] frame_cnt, err_cnt, last_len;

  mac_sim #(.DEPTH(DEPTH), .IFG_CYCLES(IFG)) u_dut (
    .clk(clk), .rst(rst), .data(data), .eop(eop), .err(err), .mod(mod),
    .rdy(rdy), .sop(sop), .wren(wren), .tx_data(tx_data), .tx_en(tx_en),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .last_len(last_len)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_errors = 0;
  logic [7:0]  exp_q[$];
  int unsigned len_q[$];
  bit          mon_on = 1'b0;
  int unsigned run_len = 0, idle_len = 0, last_gap = 0;
  int unsigned stall_cycles = 0;
  int unsigned exp_frames = 0, exp_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkword(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1;
    b2 = b + 8'd2;
    b3 = b + 8'd3;
    return {b, b1, b2, b3};
  endfunction

  // Offer one word and hold it until the DUT takes it
  task automatic put(input logic [31:0] d, input logic s, input logic e,
                     input logic [1:0] m, input logic er);
    int unsigned guard = 0;
    data = d; sop = s; eop = e; mod = m; err = er; wren = 1'b1;
    @(negedge clk);
    while (!rdy) begin
      stall_cycles++;
      guard++;
      if (guard > 5000) begin
        check("rdy_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    wren = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; mod = '0;
  endtask

  // n-word frame of incrementing bytes starting at b0
  task automatic send_frame(input int unsigned n, input logic [7:0] b0,
                            input logic [1:0] m, input logic er, input bit good);
    logic [7:0] bb;
    if (good) begin
      bb = b0;
      for (int unsigned i = 0; i < 4 * n - m; i++) begin
        exp_q.push_back(bb);
        bb = bb + 8'd1;
      end
      len_q.push_back(4 * n - m);
      exp_frames++;
    end
    bb = b0;
    for (int unsigned i = 0; i < n; i++) begin
      put(mkword(bb), i == 0, i == n - 1, (i == n - 1) ? m : 2'd0, (i == n - 1) ? er : 1'b0);
      bb = bb + 8'd4;
    end
  endtask

  task automatic wait_idle();
    int unsigned guard = 0;
    while ((exp_q.size() != 0 || tx_en) && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 5000) check("idle_timeout", guard, 32'd0);
    repeat (IFG + 4) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, exp_frames);
    check({tag, "_err_cnt"}, {16'd0, err_cnt}, exp_errs);
  endtask

  // Output monitor: every emitted byte is popped from the scoreboard
  always @(posedge clk) begin
    #1;
    if (!mon_on) begin
      run_len  = 0;
      idle_len = 0;
    end else if (tx_en) begin
      if (run_len == 0) last_gap = idle_len;
      run_len++;
      idle_len = 0;
      if (exp_q.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'h100);
      else                   check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end else begin
      if (run_len != 0) begin
        if (len_q.size() == 0) check("frame_unexpected", run_len, 32'd0);
        else                   check("frame_len", run_len, len_q.pop_front());
        run_len = 0;
      end
      idle_len++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned guard;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", rdy, 32'd0);
    check("rst_tx_en", tx_en, 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_err_cnt", err_cnt, 32'd0);
    check("rst_last_len", last_len, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rdy_after_rst", rdy, 32'd1);
    mon_on = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Long frame, bytes 0x00..0xCF
    stall_cycles = 0;
    send_frame(52, 8'h00, 2'd0, 1'b0, 1'b1);
    check("t1_last_len", last_len, 32'd208);
    check("t1_no_stall", stall_cycles, 32'd0);
    wait_idle();
    check_counts("t1");

    // Single-word frames, with first-byte latency
    exp_q.push_back(8'hAA);
    len_q.push_back(1);
    exp_frames++;
    put(32'hAABBCCDD, 1'b1, 1'b1, 2'd3, 1'b0);
    check("t2_last_len_a", last_len, 32'd1);
    check("t2_lat0", tx_en, 32'd0);
    @(posedge clk);
    #1;
    check("t2_lat1", tx_en, 32'd0);
    @(posedge clk);
    #1;
    check("t2_lat2", tx_en, 32'd1);
    wait_idle();
    check_counts("t2a");
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
    len_q.push_back(3);
    exp_frames++;
    put(32'hAABBCCDD, 1'b1, 1'b1, 2'd1, 1'b0);
    check("t2_last_len_b", last_len, 32'd3);
    wait_idle();
    check_counts("t2b");

    // Errored frame dropped, then a good one
    send_frame(5, 8'h10, 2'd0, 1'b1, 1'b0);
    exp_errs++;
    check("t3_err_cnt_now", err_cnt, exp_errs);
    check("t3_last_len_kept", last_len, 32'd3);
    wait_idle();
    send_frame(3, 8'h40, 2'd2, 1'b0, 1'b1);
    check("t3_last_len", last_len, 32'd10);
    wait_idle();
    check_counts("t3");

    // Stray words without sop, then a good frame
    put(32'h11111111, 1'b0, 1'b0, 2'd0, 1'b0);
    put(32'h22222222, 1'b0, 1'b0, 2'd0, 1'b0);
    put(32'h33333333, 1'b0, 1'b1, 2'd0, 1'b0);
    exp_errs++;
    send_frame(2, 8'h80, 2'd0, 1'b0, 1'b1);
    check("t4_last_len", last_len, 32'd8);
    wait_idle();
    check_counts("t4");

    // Second sop mid-frame aborts the first frame
    put(mkword(8'hC0), 1'b1, 1'b0, 2'd0, 1'b0);
    put(mkword(8'hC4), 1'b0, 1'b0, 2'd0, 1'b0);
    exp_errs++;
    send_frame(4, 8'h50, 2'd1, 1'b0, 1'b1);
    check("t5_last_len", last_len, 32'd15);
    wait_idle();
    check_counts("t5");

    // Back-to-back frames: gap is exactly IFG
    send_frame(4, 8'h60, 2'd0, 1'b0, 1'b1);
    send_frame(4, 8'h70, 2'd3, 1'b0, 1'b1);
    wait_idle();
    check("t6_gap", last_gap, IFG);
    check_counts("t6a");

    // Oversize frame fills the buffer and is aborted
    stall_cycles = 0;
    for (int unsigned i = 0; i < DEPTH + 6; i++)
      put(mkword(8'(i * 4)), i == 0, i == DEPTH + 5, 2'd0, 1'b0);
    exp_errs++;
    check("t6_rdy_low", stall_cycles != 0, 32'd1);
    send_frame(2, 8'hE0, 2'd0, 1'b0, 1'b1);
    wait_idle();
    check_counts("t6b");
    check("t6_len_q_empty", len_q.size(), 32'd0);

    // Reset in the middle of a transmission
    send_frame(10, 8'h20, 2'd0, 1'b0, 1'b1);
    guard = 0;
    while (!tx_en && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("t7_tx_started", tx_en, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t7_tx_en", tx_en, 32'd0);
    check("t7_frame_cnt", frame_cnt, 32'd0);
    check("t7_err_cnt", err_cnt, 32'd0);
    check("t7_last_len", last_len, 32'd0);
    check("t7_rdy_in_rst", rdy, 32'd0);
    exp_q.delete();
    len_q.delete();
    exp_frames = 0;
    exp_errs = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t7_rdy_after", rdy, 32'd1);
    mon_on = 1'b1;
    send_frame(3, 8'h90, 2'd0, 1'b0, 1'b1);
    check("t7_post_last_len", last_len, 32'd12);
    wait_idle();
    check_counts("t7");
    check("t7_len_q_empty", len_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
